// File: rtl/ts_rx_framer_pkg.sv
// Shared symbol constants, framer state encoding and the TS identifier check
// used by the receive-side TS framer.
package ts_rx_framer_pkg;

  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] TS1_IDTFR = 8'h4A;
  localparam logic [7:0] TS2_IDTFR = 8'h45;
  localparam logic [7:0] PADG12    = 8'hF7;

  typedef enum logic {
    RXF_HUNT    = 1'b0,
    RXF_COLLECT = 1'b1
  } rxf_state_e;

  // Symbol 0 is the most significant byte of the packed 128-bit word.
  typedef logic [0:15][7:0] ts_syms_t;

  // Returns {good, is_ts2}; symbols 6..15 must all be data chars of one identifier.
  function automatic logic [1:0] ts_id_check(input ts_syms_t syms, input logic [0:15] ks);
    logic all_ts1;
    logic all_ts2;
    all_ts1 = 1'b1;
    all_ts2 = 1'b1;
    for (int i = 6; i < 16; i++) begin
      if (ks[i] || (syms[i] != TS1_IDTFR)) all_ts1 = 1'b0;
      if (ks[i] || (syms[i] != TS2_IDTFR)) all_ts2 = 1'b0;
    end
    return {all_ts1 | all_ts2, all_ts2};
  endfunction

endpackage

// File: rtl/ts_rx_framer_if.sv
// Symbol stream in, assembled TS and link status out, plus framer state for debug.
interface ts_rx_framer_if
  import ts_rx_framer_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) ();

  // Stream semantics: a symbol is consumed on every clk edge where rx_sym_vld is
  // high; there is no back-pressure. remote_ts_valid is a one-cycle pulse that
  // qualifies remote_ts, remote_ts_is_ts2 and remote_ts_same.
  logic                 rx_sym_vld;
  logic [7:0]           rx_sym;
  logic                 rx_sym_k;
  logic                 remote_ts_valid;
  logic [127:0]         remote_ts;
  logic                 remote_ts_is_ts2;
  logic                 remote_ts_same;
  logic                 rx_locked;
  logic [ERR_CNT_W-1:0] rx_err_cnt;
  rxf_state_e           state_dbg;

  modport master (
    output rx_sym_vld, rx_sym, rx_sym_k,
    input  remote_ts_valid, remote_ts, remote_ts_is_ts2, remote_ts_same,
    input  rx_locked, rx_err_cnt, state_dbg
  );

  modport slave (
    input  rx_sym_vld, rx_sym, rx_sym_k,
    output remote_ts_valid, remote_ts, remote_ts_is_ts2, remote_ts_same,
    output rx_locked, rx_err_cnt, state_dbg
  );

endinterface

// File: rtl/ts_rx_framer.sv
// Aligns on COM, assembles 16-symbol TS1/TS2 ordered sets, validates the
// identifier field and tracks lock plus a saturating malformed-TS count.
module ts_rx_framer
  import ts_rx_framer_pkg::*;
#(
  parameter int LOCK_GOOD  = 2,
  parameter int UNLOCK_BAD = 4,
  parameter int ERR_CNT_W  = 8
) (
  input logic          clk,
  input logic          rst,
  ts_rx_framer_if.slave rx
);

  localparam int CNT_MAX = (LOCK_GOOD > UNLOCK_BAD) ? LOCK_GOOD : UNLOCK_BAD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_TH   = CNT_W'(LOCK_GOOD);
  localparam logic [CNT_W-1:0] UNLOCK_TH = CNT_W'(UNLOCK_BAD);

  rxf_state_e           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  ts_syms_t             syms_q, syms_d;
  logic [0:15]          ks_q, ks_d;
  ts_syms_t             ts_q, ts_d;
  logic                 valid_q, valid_d;
  logic                 is_ts2_q, is_ts2_d;
  logic                 same_q, same_d;
  logic                 locked_q, locked_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0]     good_q, good_d;
  logic [CNT_W-1:0]     bad_q, bad_d;

  logic       is_com;
  logic       good_evt;
  logic       bad_evt;
  logic [1:0] id_chk;

  assign is_com = rx.rx_sym_vld && rx.rx_sym_k && (rx.rx_sym == COM);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    syms_d   = syms_q;
    ks_d     = ks_q;
    good_evt = 1'b0;
    bad_evt  = 1'b0;
    id_chk   = 2'b00;
    case (state_q)
      RXF_HUNT: begin
        if (is_com) begin
          syms_d[0] = COM;
          ks_d[0]   = 1'b1;
          idx_d     = 4'd1;
          state_d   = RXF_COLLECT;
        end
      end
      RXF_COLLECT: begin
        if (is_com) begin
          // Truncated TS: the early COM restarts assembly as the new symbol 0.
          bad_evt   = 1'b1;
          syms_d[0] = COM;
          ks_d[0]   = 1'b1;
          idx_d     = 4'd1;
        end else if (rx.rx_sym_vld) begin
          syms_d[idx_q] = rx.rx_sym;
          ks_d[idx_q]   = rx.rx_sym_k;
          idx_d         = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d  = RXF_HUNT;
            idx_d    = 4'd0;
            id_chk   = ts_id_check(syms_d, ks_d);
            good_evt = id_chk[1];
            bad_evt  = !id_chk[1];
          end
        end
      end
      default: state_d = RXF_HUNT;
    endcase
  end

  always_comb begin
    valid_d  = good_evt;
    ts_d     = ts_q;
    is_ts2_d = is_ts2_q;
    same_d   = same_q;
    locked_d = locked_q;
    err_d    = err_q;
    good_d   = good_q;
    bad_d    = bad_q;
    if (good_evt) begin
      // ts_q is zero after reset and a TS always starts with COM, so the first is never "same".
      ts_d     = syms_d;
      is_ts2_d = id_chk[0];
      same_d   = (syms_d == ts_q);
      bad_d    = '0;
      if (good_q != LOCK_TH) good_d = good_q + 1'b1;
      if (good_d == LOCK_TH) locked_d = 1'b1;
    end
    if (bad_evt) begin
      good_d = '0;
      if (bad_q != UNLOCK_TH) bad_d = bad_q + 1'b1;
      if (bad_d == UNLOCK_TH) locked_d = 1'b0;
      if (err_q != '1) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RXF_HUNT;
      idx_q    <= '0;
      syms_q   <= '0;
      ks_q     <= '0;
      ts_q     <= '0;
      valid_q  <= 1'b0;
      is_ts2_q <= 1'b0;
      same_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      syms_q   <= syms_d;
      ks_q     <= ks_d;
      ts_q     <= ts_d;
      valid_q  <= valid_d;
      is_ts2_q <= is_ts2_d;
      same_q   <= same_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  assign rx.remote_ts_valid  = valid_q;
  assign rx.remote_ts        = ts_q;
  assign rx.remote_ts_is_ts2 = is_ts2_q;
  assign rx.remote_ts_same   = same_q;
  assign rx.rx_locked        = locked_q;
  assign rx.rx_err_cnt       = err_q;
  assign rx.state_dbg        = state_q;

endmodule

// File: tb/tb_ts_rx_framer.sv
// Directed bench for ts_rx_framer: scoreboard of expected TS words checked on
// every valid pulse, plus directed checks of lock, error count and reset.
module tb_ts_rx_framer;
  import ts_rx_framer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ts_rx_framer_if #(.ERR_CNT_W(8)) rx ();

  ts_rx_framer #(
    .LOCK_GOOD (2),
    .UNLOCK_BAD(4),
    .ERR_CNT_W (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pulse_cnt  = 0;
  int prev_pulse = 0;
  int last_pulse = 0;
  bit stall_en   = 1'b0;
  logic [129:0] exp_q[$];

  ts_syms_t    ts_a, ts_b, ts_c;
  logic [0:15] ks_std;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: {is_ts2, same, remote_ts} compared on each valid pulse.
  always @(negedge clk) begin : monitor
    logic [129:0] e;
    if (rst === 1'b0 && rx.remote_ts_valid === 1'b1) begin
      pulse_cnt++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 130'd1, 130'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ts_word", {rx.remote_ts_is_ts2, rx.remote_ts_same, rx.remote_ts}, e);
      end
    end
  end

  task automatic drive_sym(input logic [7:0] s, input logic k);
    int n;
    if (stall_en) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        rx.rx_sym_vld = 1'b0;
        rx.rx_sym     = COM;
        rx.rx_sym_k   = 1'b1;
      end
    end
    @(negedge clk);
    rx.rx_sym_vld = 1'b1;
    rx.rx_sym     = s;
    rx.rx_sym_k   = k;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx.rx_sym_vld = 1'b0;
    end
  endtask

  task automatic send_ts(input ts_syms_t s, input logic [0:15] ks, input int first, input int last);
    for (int i = first; i <= last; i++) drive_sym(s[i], ks[i]);
  endtask

  task automatic push_exp(input logic is_ts2, input logic same, input ts_syms_t w);
    exp_q.push_back({is_ts2, same, w});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},  rx.remote_ts_valid,  0);
    chk({tag, "_ts"},     rx.remote_ts,        0);
    chk({tag, "_is_ts2"}, rx.remote_ts_is_ts2, 0);
    chk({tag, "_same"},   rx.remote_ts_same,   0);
    chk({tag, "_locked"}, rx.rx_locked,        0);
    chk({tag, "_err"},    rx.rx_err_cnt,       0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ts_a   = {COM, PADG12, PADG12, 8'hFF, 8'h07, 8'h00, {10{TS1_IDTFR}}};
    ts_b   = {COM, PADG12, PADG12, 8'hFF, 8'h07, 8'h00, {10{TS2_IDTFR}}};
    ts_c   = ts_a;
    ts_c[10] = 8'h4B;
    ks_std = 16'hE000;

    // Reset
    rst = 1'b1;
    rx.rx_sym_vld = 1'b0;
    rx.rx_sym     = 8'h00;
    rx.rx_sym_k   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // 1: single TS1, pulse exactly one cycle after symbol 15
    exp_q.push_back({2'b00, 128'hBCF7F7FF07004A4A4A4A4A4A4A4A4A4A});
    send_ts(ts_a, ks_std, 0, 15);
    @(negedge clk);
    rx.rx_sym_vld = 1'b0;
    chk("t1_valid_latency", rx.remote_ts_valid, 1);
    chk("t1_err", rx.rx_err_cnt, 0);
    chk("t1_locked", rx.rx_locked, 0);
    @(negedge clk);
    chk("t1_valid_one_cycle", rx.remote_ts_valid, 0);
    chk("t1_pulses", pulse_cnt, 1);

    // 2: identical TS1 x2 back-to-back
    push_exp(1'b0, 1'b1, ts_a);
    push_exp(1'b0, 1'b1, ts_a);
    send_ts(ts_a, ks_std, 0, 15);
    send_ts(ts_a, ks_std, 0, 15);
    idle(2);
    chk("t2_pulses", pulse_cnt, 3);
    chk("t2_spacing", last_pulse - prev_pulse, 16);
    chk("t2_locked", rx.rx_locked, 1);

    // 3: garbage in HUNT is dropped silently, then TS2
    for (int i = 0; i < 5; i++) drive_sym(8'($urandom_range(0, 8'hBB)), 1'b0);
    push_exp(1'b1, 1'b0, ts_b);
    send_ts(ts_b, ks_std, 0, 15);
    idle(2);
    chk("t3_pulses", pulse_cnt, 4);
    chk("t3_err", rx.rx_err_cnt, 0);

    // 4: bad identifier at symbol 10; four of them drop lock
    send_ts(ts_c, ks_std, 0, 15);
    idle(2);
    chk("t4_no_pulse", pulse_cnt, 4);
    chk("t4_err1", rx.rx_err_cnt, 1);
    chk("t4_ts_held", rx.remote_ts, ts_b);
    chk("t4_locked_after1", rx.rx_locked, 1);
    send_ts(ts_c, ks_std, 0, 15);
    send_ts(ts_c, ks_std, 0, 15);
    idle(2);
    chk("t4_locked_after3", rx.rx_locked, 1);
    send_ts(ts_c, ks_std, 0, 15);
    idle(2);
    chk("t4_locked_after4", rx.rx_locked, 0);
    chk("t4_err4", rx.rx_err_cnt, 4);

    // 5: COM at idx 8 truncates, then a complete TS follows
    send_ts(ts_a, ks_std, 0, 7);
    push_exp(1'b0, 1'b0, ts_a);
    send_ts(ts_a, ks_std, 0, 15);
    idle(2);
    chk("t5_err", rx.rx_err_cnt, 5);
    chk("t5_pulses", pulse_cnt, 5);
    chk("t5_locked", rx.rx_locked, 0);
    push_exp(1'b0, 1'b1, ts_a);
    send_ts(ts_a, ks_std, 0, 15);
    idle(2);
    chk("t5_relock", rx.rx_locked, 1);

    // 6: random stalls inside TSs, then reset mid-TS
    stall_en = 1'b1;
    push_exp(1'b1, 1'b0, ts_b);
    push_exp(1'b1, 1'b1, ts_b);
    send_ts(ts_b, ks_std, 0, 15);
    send_ts(ts_b, ks_std, 0, 15);
    idle(2);
    chk("t6_stall_pulses", pulse_cnt, 8);
    send_ts(ts_a, ks_std, 0, 9);
    @(negedge clk);
    rst = 1'b1;
    rx.rx_sym_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("midrst");
    rst = 1'b0;
    stall_en = 1'b0;
    send_ts(ts_a, ks_std, 10, 15);
    idle(2);
    chk("t6_no_partial_pulse", pulse_cnt, 8);
    chk("t6_no_partial_err", rx.rx_err_cnt, 0);
    push_exp(1'b0, 1'b0, ts_a);
    send_ts(ts_a, ks_std, 0, 15);
    idle(2);
    chk("t6_post_reset_pulse", pulse_cnt, 9);

    // 7: error counter saturates at all-ones
    for (int i = 0; i < 256; i++) send_ts(ts_c, ks_std, 0, 15);
    idle(2);
    chk("t7_err_sat", rx.rx_err_cnt, 8'hFF);
    chk("t7_locked", rx.rx_locked, 0);
    chk("t7_pulses", pulse_cnt, 9);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
